// File: rtl/mem_arbiter_pkg.sv
// Shared types and default geometry for the icache/dcache memory arbiter.
package mem_arbiter_pkg;

    localparam int DEF_BEAT_W = 64;
    localparam int DEF_BEATS  = 4;
    localparam int DEF_LINE_W = DEF_BEAT_W * DEF_BEATS;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        I_RD = 3'd1,
        D_RD = 3'd2,
        D_WR = 3'd3,
        DONE = 3'd4
    } arb_state_t;

    // Bursts always start on a 32-byte line boundary.
    function automatic logic [31:0] line_base(input logic [31:0] addr);
        return {addr[31:5], 5'b0};
    endfunction

endpackage

// File: rtl/line_buffer.sv
// Line register shared by all bursts: assembles read beats into a line and
// serialises a latched writeback line one beat at a time.
module line_buffer
    import mem_arbiter_pkg::*;
#(
    parameter int BEAT_W = DEF_BEAT_W,
    parameter int BEATS  = DEF_BEATS,
    parameter int CNT_W  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [BEAT_W*BEATS-1:0]   load_line,
    input  logic                      capture,
    input  logic [CNT_W-1:0]          slot,
    input  logic [BEAT_W-1:0]         beat_in,
    output logic [BEAT_W*BEATS-1:0]   line_merged,
    output logic [BEAT_W-1:0]         beat_out
);

    logic [BEAT_W*BEATS-1:0] line_q;

    // line_merged is the line as it will look once the current beat lands,
    // so the final beat can be forwarded in the same cycle it arrives.
    always_comb begin
        line_merged = line_q;
        beat_out    = '0;
        for (int k = 0; k < BEATS; k++) begin
            if (slot == CNT_W'(k)) begin
                line_merged[k*BEAT_W +: BEAT_W] = beat_in;
                beat_out                        = line_q[k*BEAT_W +: BEAT_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_q <= '0;
        end else if (load) begin
            line_q <= load_line;
        end else if (capture) begin
            line_q <= line_merged;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates icache fills and dcache fills/writebacks onto one burst memory
// port; dcache wins over icache and a dcache writeback wins over its fill.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int BEAT_W = DEF_BEAT_W,
    parameter int BEATS  = DEF_BEATS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_read,
    input  logic [31:0]               i_address,
    output logic [BEAT_W*BEATS-1:0]   i_rdata,
    output logic                      i_resp,
    input  logic                      d_read,
    input  logic                      d_write,
    input  logic [31:0]               d_address,
    input  logic [BEAT_W*BEATS-1:0]   d_wdata,
    output logic [BEAT_W*BEATS-1:0]   d_rdata,
    output logic                      d_resp,
    output logic                      mem_read,
    output logic                      mem_write,
    output logic [31:0]               mem_address,
    output logic [BEAT_W-1:0]         mem_wdata,
    input  logic [BEAT_W-1:0]         mem_rdata,
    input  logic                      mem_resp,
    output logic [2:0]                dbg_state
);

    localparam int LINE_W = BEAT_W * BEATS;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    // Handshake: requests are levels sampled only in IDLE; once granted, the
    // burst runs to completion regardless of the request. mem_read/mem_write
    // act as valid and hold until the last beat; each mem_resp acknowledges
    // exactly one beat, and gaps simply stall the beat counter.
    arb_state_t       state;
    logic [CNT_W-1:0] beat_cnt;
    logic [LINE_W-1:0] line_merged;
    logic             load;
    logic             capture;
    logic             in_burst;
    logic             last_beat;

    assign dbg_state = state;
    assign load      = (state == IDLE) && d_write;
    assign capture   = mem_resp && ((state == I_RD) || (state == D_RD));
    assign in_burst  = (state == I_RD) || (state == D_RD) || (state == D_WR);
    assign last_beat = in_burst && mem_resp && (beat_cnt == LAST_BEAT);

    line_buffer #(
        .BEAT_W (BEAT_W),
        .BEATS  (BEATS),
        .CNT_W  (CNT_W)
    ) u_line_buffer (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .load_line   (d_wdata),
        .capture     (capture),
        .slot        (beat_cnt),
        .beat_in     (mem_rdata),
        .line_merged (line_merged),
        .beat_out    (mem_wdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            beat_cnt    <= '0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            i_resp      <= 1'b0;
            d_resp      <= 1'b0;
            i_rdata     <= '0;
            d_rdata     <= '0;
        end else begin
            i_resp <= 1'b0;
            d_resp <= 1'b0;
            case (state)
                IDLE: begin
                    beat_cnt <= '0;
                    if (d_write) begin
                        state       <= D_WR;
                        mem_write   <= 1'b1;
                        mem_address <= line_base(d_address);
                    end else if (d_read) begin
                        state       <= D_RD;
                        mem_read    <= 1'b1;
                        mem_address <= line_base(d_address);
                    end else if (i_read) begin
                        state       <= I_RD;
                        mem_read    <= 1'b1;
                        mem_address <= line_base(i_address);
                    end
                end
                I_RD, D_RD, D_WR: begin
                    if (last_beat) begin
                        state     <= DONE;
                        beat_cnt  <= '0;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        if (state == I_RD) begin
                            i_resp  <= 1'b1;
                            i_rdata <= line_merged;
                        end else begin
                            d_resp <= 1'b1;
                            if (state == D_RD) begin
                                d_rdata <= line_merged;
                            end
                        end
                    end else if (mem_resp) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table vectors, hand-written corner sequences and
// random bursts, all checked against a line-level model of the arbiter.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int BW = 64;
    localparam int NB = 4;
    localparam int LW = BW * NB;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_read = 1'b0;
    logic [31:0]   i_address = '0;
    logic [LW-1:0] i_rdata;
    logic          i_resp;
    logic          d_read = 1'b0;
    logic          d_write = 1'b0;
    logic [31:0]   d_address = '0;
    logic [LW-1:0] d_wdata = '0;
    logic [LW-1:0] d_rdata;
    logic          d_resp;
    logic          mem_read;
    logic          mem_write;
    logic [31:0]   mem_address;
    logic [BW-1:0] mem_wdata;
    logic [BW-1:0] mem_rdata = '0;
    logic          mem_resp = 1'b0;
    logic [2:0]    dbg_state;

    mem_arbiter #(.BEAT_W(BW), .BEATS(NB)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_read      (i_read),
        .i_address   (i_address),
        .i_rdata     (i_rdata),
        .i_resp      (i_resp),
        .d_read      (d_read),
        .d_write     (d_write),
        .d_address   (d_address),
        .d_wdata     (d_wdata),
        .d_rdata     (d_rdata),
        .d_resp      (d_resp),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_resp    (mem_resp),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    int            n_checks = 0;
    int            n_errors = 0;
    logic [LW-1:0] exp_i_line = '0;
    logic [LW-1:0] exp_d_line = '0;
    logic [BW-1:0] exp_q[$];

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] busy_state(input int kind);
        if (kind == 0) return 3'(I_RD);
        if (kind == 1) return 3'(D_RD);
        return 3'(D_WR);
    endfunction

    // ---------------- driver tasks ----------------
    // kind: 0 = icache fill, 1 = dcache fill, 2 = dcache writeback
    task automatic start_req(input int kind, input logic [31:0] addr,
                             input logic [LW-1:0] wdata, input logic both);
        if (kind == 0) begin
            i_read    = 1'b1;
            i_address = addr;
        end else begin
            d_read    = (kind == 1) || both;
            d_write   = (kind == 2);
            d_address = addr;
            d_wdata   = wdata;
        end
        @(posedge clk); #1;
    endtask

    task automatic drop_reqs();
        i_read  = 1'b0;
        d_read  = 1'b0;
        d_write = 1'b0;
    endtask

    // Acts as memory from the first cycle after the grant edge; data holds
    // the beats to return (reads) or the line being written back (writes).
    task automatic burst(input int kind, input logic [31:0] exp_addr,
                         input logic [LW-1:0] data, input logic [15:0] pat, input int len);
        int k;
        k = 0;
        if (kind == 2) begin
            for (int b = 0; b < NB; b++) exp_q.push_back(data[b*BW +: BW]);
        end
        for (int j = 0; j < len; j++) begin
            mem_resp  = pat[j];
            mem_rdata = {$urandom, $urandom};
            if (pat[j] && k < NB) mem_rdata = data[k*BW +: BW];
            @(negedge clk);
            chk("burst_state", LW'(dbg_state), LW'(busy_state(kind)));
            chk("mem_address", LW'(mem_address), LW'(exp_addr));
            chk("mem_read", LW'(mem_read), LW'(kind != 2));
            chk("mem_write", LW'(mem_write), LW'(kind == 2));
            chk("resp_early", LW'({i_resp, d_resp}), '0);
            if (kind == 2) begin
                chk("mem_wdata", LW'(mem_wdata), (exp_q.size() > 0) ? LW'(exp_q[0]) : '0);
                if (pat[j] && exp_q.size() > 0) void'(exp_q.pop_front());
            end
            if (pat[j]) k++;
            @(posedge clk); #1;
        end
        mem_resp  = 1'b1;
        mem_rdata = {$urandom, $urandom};
        if (kind == 0) exp_i_line = data;
        if (kind == 1) exp_d_line = data;
        @(negedge clk);
        chk("done_state", LW'(dbg_state), LW'(3'(DONE)));
        chk("i_resp", LW'(i_resp), LW'(kind == 0));
        chk("d_resp", LW'(d_resp), LW'(kind != 0));
        chk("mem_rw_off", LW'({mem_read, mem_write}), '0);
        chk("i_rdata", i_rdata, exp_i_line);
        chk("d_rdata", d_rdata, exp_d_line);
        @(posedge clk); #1;
        mem_resp = 1'b0;
        @(negedge clk);
        chk("post_idle", LW'(dbg_state), LW'(3'(IDLE)));
        chk("resp_pulse_end", LW'({i_resp, d_resp}), '0);
        chk("i_rdata_hold", i_rdata, exp_i_line);
        chk("d_rdata_hold", d_rdata, exp_d_line);
        @(posedge clk); #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_state"}, LW'(dbg_state), LW'(3'(IDLE)));
        chk({tag, "_mem_rw"}, LW'({mem_read, mem_write}), '0);
        chk({tag, "_mem_address"}, LW'(mem_address), '0);
        chk({tag, "_mem_wdata"}, LW'(mem_wdata), '0);
        chk({tag, "_resp"}, LW'({i_resp, d_resp}), '0);
        chk({tag, "_i_rdata"}, i_rdata, '0);
        chk({tag, "_d_rdata"}, d_rdata, '0);
    endtask

    // ---------------- stimulus ----------------
    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] exp_addr;
        logic [LW-1:0] data;
        logic [15:0] pat;
        int          len;
    } vec_t;

    vec_t          vecs[3];
    logic [LW-1:0] line_a;
    logic [LW-1:0] line_b;
    logic [LW-1:0] rdata;
    logic [15:0]   pat;
    int            len;
    int            kind;
    logic [31:0]   addr;
    logic          both;

    initial begin
        line_a = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
        line_b = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
        vecs[0] = '{1, 32'hFFFF_FFFF, 32'hFFFF_FFE0, {{16{4'h9}}, {16{4'h8}}, {16{4'h7}}, {16{4'h6}}}, 16'h0059, 7};
        vecs[1] = '{2, 32'h1234_5678, 32'h1234_5660, line_b, 16'h000F, 4};
        vecs[2] = '{0, 32'h0000_0020, 32'h0000_0020, {4{64'h0123_4567_89AB_CDEF}}, 16'h0055, 7};

        // reset with a pending icache request; no grant until rst is high
        i_read    = 1'b1;
        i_address = 32'h0000_0064;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b1;
        @(negedge clk);
        chk("no_grant_before_release", LW'(mem_read), '0);
        @(posedge clk); #1;
        drop_reqs();
        burst(0, 32'h0000_0060, line_a, 16'h000F, 4);

        // table vectors: gapped dcache fill, writeback, gapped icache fill
        for (int v = 0; v < 3; v++) begin
            start_req(vecs[v].kind, vecs[v].addr, vecs[v].data, 1'b0);
            drop_reqs();
            burst(vecs[v].kind, vecs[v].exp_addr, vecs[v].data, vecs[v].pat, vecs[v].len);
        end

        // simultaneous icache and dcache fills: dcache first, icache right after
        i_read    = 1'b1;
        i_address = 32'h0000_1004;
        start_req(1, 32'h0000_2008, '0, 1'b0);
        d_read = 1'b0;
        burst(1, 32'h0000_2000, line_b, 16'h000F, 4);
        i_read = 1'b0;
        burst(0, 32'h0000_1000, line_a, 16'h000F, 4);

        // spurious mem_resp while idle, then read+write together
        for (int s = 0; s < 3; s++) begin
            mem_resp  = 1'b1;
            mem_rdata = {$urandom, $urandom};
            @(negedge clk);
            chk("spurious_idle", LW'(dbg_state), LW'(3'(IDLE)));
            chk("spurious_mem_rw", LW'({mem_read, mem_write}), '0);
            chk("spurious_i_rdata", i_rdata, exp_i_line);
            @(posedge clk); #1;
        end
        mem_resp = 1'b0;
        start_req(2, 32'h0000_3333, line_a, 1'b1);
        drop_reqs();
        burst(2, 32'h0000_3320, line_a, 16'h000F, 4);

        // random bursts with random beat gaps
        for (int t = 0; t < 25; t++) begin
            kind = $urandom_range(0, 2);
            addr = $urandom;
            both = (kind == 2) && ($urandom_range(0, 1) == 1);
            for (int b = 0; b < NB; b++) rdata[b*BW +: BW] = {$urandom, $urandom};
            pat = '0;
            len = 0;
            for (int b = 0; b < NB; b++) begin
                len += $urandom_range(0, 2);
                pat[len] = 1'b1;
                len++;
            end
            if ($urandom_range(0, 3) == 0) begin
                mem_resp = 1'b1;
                @(negedge clk);
                chk("rand_spurious", LW'(dbg_state), LW'(3'(IDLE)));
                @(posedge clk); #1;
                mem_resp = 1'b0;
            end
            start_req(kind, addr, rdata, both);
            drop_reqs();
            burst(kind, addr & 32'hFFFF_FFE0, rdata, pat, len);
        end

        // asynchronous reset two beats into a dcache fill
        start_req(1, 32'h0000_4040, '0, 1'b0);
        drop_reqs();
        for (int b = 0; b < 2; b++) begin
            mem_resp  = 1'b1;
            mem_rdata = {$urandom, $urandom};
            @(posedge clk); #1;
        end
        mem_resp = 1'b0;
        @(negedge clk);
        chk("pre_reset_mem_read", LW'(mem_read), LW'(1'b1));
        #1;
        rst = 1'b0;
        #1;
        check_all_zero("async_reset");
        exp_i_line = '0;
        exp_d_line = '0;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        start_req(1, 32'h0000_5055, '0, 1'b0);
        drop_reqs();
        burst(1, 32'h0000_5040, line_b, 16'h001D, 5);

        chk("wdata_queue_drained", LW'(exp_q.size()), '0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
